// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encodings, state width and byte-lane count.
package mem_responder_pkg;

    localparam int MR_STATE_W = 2;
    localparam int MR_LANES   = 4;

    typedef enum logic [MR_STATE_W-1:0] {
        MR_IDLE   = 2'd0,
        MR_WAIT   = 2'd1,
        MR_ACCESS = 2'd2,
        MR_RESP   = 2'd3
    } mr_state_e;

endpackage

// File: rtl/mem_resp_sram.sv
// Single-port, byte-enabled synchronous SRAM (DEPTH x 32).
module mem_resp_sram
    import mem_responder_pkg::*;
#(
    parameter int    DEPTH     = 65536,
    parameter int    ADDR_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                we,
    input  logic [MR_LANES-1:0] wstrb,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);

    // NOTE: the storage array is deliberately never reset, so it maps onto block RAM
    // and keeps its contents across a reset of the control logic.
    logic [31:0] mem_q [DEPTH];

    // NOTE: clocked state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MR_LANES; i++) begin
            if (we && wstrb[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Load/store port responder: valid/ready request, WAIT_CYCLES wait states, byte-strobed SRAM access,
// held response. Define MEM_RESP_MISALIGN_CHECK_EN to reject accesses whose addr[1:0] != 0.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int    DEPTH       = 65536,
    parameter int    ADDR_W      = 16,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [MR_LANES-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err
);

    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

    mr_state_e           state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [MR_LANES-1:0] wstrb_q, wstrb_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                misalign;
    logic                sram_we;
    logic [ADDR_W-1:0]   sram_addr;
    logic [31:0]         sram_rdata;
    logic                unused_addr_bits;

`ifdef MEM_RESP_MISALIGN_CHECK_EN
    logic [1:0] offs_q, offs_d;
    assign misalign         = |offs_q;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
`else
    assign misalign         = 1'b0;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

    // While idle the SRAM reads the incoming address so the word is ready even with no wait states.
    assign sram_addr = (state_q == MR_IDLE) ? req_addr[ADDR_W+1:2] : addr_q;
    assign sram_we   = (state_q == MR_ACCESS) && we_q && !misalign && !reset;

    assign req_ready = (state_q == MR_IDLE) && !reset;
    assign rsp_valid = (state_q == MR_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
        offs_d  = offs_q;
`endif
        unique case (state_q)
            MR_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
                    offs_d  = req_addr[1:0];
`endif
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? MR_WAIT : MR_ACCESS;
                end
            end
            MR_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = MR_ACCESS;
            end
            MR_ACCESS: begin
                rdata_d = (we_q || misalign) ? 32'h0 : sram_rdata;
                err_d   = misalign;
                state_d = MR_RESP;
            end
            MR_RESP: begin
                if (rsp_ready) state_d = MR_IDLE;
            end
            default: state_d = MR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MR_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            wstrb_q <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
            offs_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MEM_RESP_MISALIGN_CHECK_EN
            offs_q  <= offs_d;
`endif
        end
    end

    mem_resp_sram #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .wstrb (wstrb_q),
        .addr  (sram_addr),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

endmodule
